// File: rtl/timer_pkg.sv
// Register map, CTRL layout and byte-lane helper shared by the timer block.
// No logic state; pure definitions.
// No flow control; used by combinational and registered code alike.
package timer_pkg;

    localparam logic [2:0] TMR_CTRL     = 3'd0;
    localparam logic [2:0] TMR_PRESCALE = 3'd1;
    localparam logic [2:0] TMR_RELOAD   = 3'd2;
    localparam logic [2:0] TMR_COUNT    = 3'd3;
    localparam logic [2:0] TMR_STATUS   = 3'd4;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_IE_BIT   = 1;
    localparam int CTRL_AUTO_BIT = 2;

    typedef struct packed {
        logic auto_reload;
        logic ie;
        logic en;
    } tmr_ctrl_t;

    function automatic logic [15:0] byte_merge(input logic [15:0] old_v,
                                               input logic [15:0] new_v,
                                               input logic [1:0]  be);
        return {be[1] ? new_v[15:8] : old_v[15:8],
                be[0] ? new_v[7:0]  : old_v[7:0]};
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescale divider: pulses tick once every PRESCALE+1 enabled cycles.
// tick is combinational from the held count; count updates each edge.
// No backpressure; restart forces the count to zero.
module timer_prescaler (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        restart,
    input  logic [15:0] prescale,
    output logic        tick
);

    logic [15:0] pcnt;

    assign tick = en && (pcnt == prescale);

    // A count above a freshly lowered PRESCALE wraps through 16'hFFFF.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt <= 16'h0000;
        end else if (restart || tick) begin
            pcnt <= 16'h0000;
        end else if (en) begin
            pcnt <= pcnt + 16'h0001;
        end
    end

endmodule

// File: rtl/timer_peripheral.sv
// Memory-mapped prescaled 16-bit countdown timer with level interrupt.
// Reads are combinational; writes land on the edge with dwrite_en != 0.
// No backpressure; every bus access completes in its own cycle.
module timer_peripheral
    import timer_pkg::*;
#(
    parameter logic [15:0] BASE = 16'hFF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dread_addr,
    output logic [15:0] dread_data,
    input  logic [15:0] dwrite_addr,
    input  logic [15:0] dwrite_data,
    input  logic [1:0]  dwrite_en,
    output logic        interrupt
);

    tmr_ctrl_t   ctrl;
    logic [15:0] prescale;
    logic [15:0] reload;
    logic [15:0] count;
    logic        pend;
    logic        tick;

    logic        wr_hit;
    logic [2:0]  wr_idx;
    logic        wr_ctrl;
    logic        wr_pre;
    logic        wr_rel;
    logic        wr_cnt;
    logic        w1c_pend;
    logic        restart;
    logic        expire;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = dread_addr[0] ^ dwrite_addr[0];

    assign wr_hit   = (dwrite_en != 2'b00) && (dwrite_addr[15:4] == BASE[15:4]);
    assign wr_idx   = dwrite_addr[3:1];
    // CTRL and STATUS bits all live in the low byte lane.
    assign wr_ctrl  = wr_hit && (wr_idx == TMR_CTRL) && dwrite_en[0];
    assign wr_pre   = wr_hit && (wr_idx == TMR_PRESCALE);
    assign wr_rel   = wr_hit && (wr_idx == TMR_RELOAD);
    assign wr_cnt   = wr_hit && (wr_idx == TMR_COUNT);
    assign w1c_pend = wr_hit && (wr_idx == TMR_STATUS) && dwrite_en[0] && dwrite_data[0];
    assign restart  = wr_ctrl && !ctrl.en && dwrite_data[CTRL_EN_BIT];
    // A CPU write to COUNT preempts both the decrement and expiry.
    assign expire   = tick && (count == 16'h0000) && !wr_cnt;

    timer_prescaler u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (ctrl.en),
        .restart  (restart),
        .prescale (prescale),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl     <= '0;
            prescale <= 16'h0000;
            reload   <= 16'h0000;
            count    <= 16'h0000;
            pend     <= 1'b0;
        end else begin
            if (wr_pre) prescale <= byte_merge(prescale, dwrite_data, dwrite_en);
            if (wr_rel) reload   <= byte_merge(reload, dwrite_data, dwrite_en);

            if (wr_cnt) begin
                count <= byte_merge(count, dwrite_data, dwrite_en);
            end else if (tick) begin
                if (count != 16'h0000)   count <= count - 16'h0001;
                else if (ctrl.auto_reload) count <= reload;
            end

            if (expire)        pend <= 1'b1;
            else if (w1c_pend) pend <= 1'b0;

            if (wr_ctrl) begin
                ctrl <= tmr_ctrl_t'(dwrite_data[CTRL_AUTO_BIT:CTRL_EN_BIT]);
            end else if (expire && !ctrl.auto_reload) begin
                ctrl.en <= 1'b0;
            end
        end
    end

    always_comb begin
        dread_data = 16'h0000;
        if (dread_addr[15:4] == BASE[15:4]) begin
            case (dread_addr[3:1])
                TMR_CTRL:     dread_data = {13'd0, ctrl};
                TMR_PRESCALE: dread_data = prescale;
                TMR_RELOAD:   dread_data = reload;
                TMR_COUNT:    dread_data = count;
                TMR_STATUS:   dread_data = {15'd0, pend};
                default:      dread_data = 16'h0000;
            endcase
        end
    end

    assign interrupt = pend & ctrl.ie;

endmodule

// File: tb/tb_timer_peripheral.sv
// Bench for timer_peripheral: directed scenarios plus random bus traffic
// compared against a rule-level reference model of the register map.
module tb_timer_peripheral;

    localparam logic [15:0] BASE = 16'hFF00;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] dread_addr;
    logic [15:0] dread_data;
    logic [15:0] dwrite_addr;
    logic [15:0] dwrite_data;
    logic [1:0]  dwrite_en;
    logic        interrupt;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic        m_en, m_ie, m_auto, m_pend;
    logic [15:0] m_pre, m_rel, m_cnt, m_pcnt;

    timer_peripheral #(.BASE(BASE)) dut (
        .clk         (clk),
        .reset       (reset),
        .dread_addr  (dread_addr),
        .dread_data  (dread_data),
        .dwrite_addr (dwrite_addr),
        .dwrite_data (dwrite_data),
        .dwrite_en   (dwrite_en),
        .interrupt   (interrupt)
    );

    always #10 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [15:0] lanes(input logic [15:0] o, input logic [15:0] n,
                                          input logic [1:0] we);
        logic [15:0] r;
        r = o;
        if (we[0]) r[7:0]  = n[7:0];
        if (we[1]) r[15:8] = n[15:8];
        return r;
    endfunction

    task automatic model_reset();
        m_en = 0; m_ie = 0; m_auto = 0; m_pend = 0;
        m_pre = 0; m_rel = 0; m_cnt = 0; m_pcnt = 0;
    endtask

    // One clock edge of the timer, applied from the register-map rules.
    task automatic model_edge(input logic [15:0] wa, input logic [15:0] wd, input logic [1:0] we);
        logic hit, tick, cnt_wr, expiry, old_en, old_auto;
        hit      = (we != 2'b00) && (wa[15:4] == BASE[15:4]);
        tick     = m_en && (m_pcnt == m_pre);
        cnt_wr   = hit && (wa[3:1] == 3'd3);
        expiry   = tick && (m_cnt == 0) && !cnt_wr;
        old_en   = m_en;
        old_auto = m_auto;

        if (m_en) m_pcnt = tick ? 16'h0 : m_pcnt + 16'h1;

        if (cnt_wr)           m_cnt = lanes(m_cnt, wd, we);
        else if (tick) begin
            if (m_cnt != 0)   m_cnt = m_cnt - 16'h1;
            else if (old_auto) m_cnt = m_rel;
        end

        if (hit && wa[3:1] == 3'd4 && we[0] && wd[0]) m_pend = 0;
        if (expiry) m_pend = 1;
        if (expiry && !old_auto) m_en = 0;

        if (hit && wa[3:1] == 3'd0 && we[0]) begin
            if (!old_en && wd[0]) m_pcnt = 16'h0;
            m_en = wd[0]; m_ie = wd[1]; m_auto = wd[2];
        end
        if (hit && wa[3:1] == 3'd1) m_pre = lanes(m_pre, wd, we);
        if (hit && wa[3:1] == 3'd2) m_rel = lanes(m_rel, wd, we);
    endtask

    function automatic logic [15:0] mread(input logic [15:0] a);
        if (a[15:4] != BASE[15:4]) return 16'h0;
        case (a[3:1])
            3'd0:    return {13'd0, m_auto, m_ie, m_en};
            3'd1:    return m_pre;
            3'd2:    return m_rel;
            3'd3:    return m_cnt;
            3'd4:    return {15'd0, m_pend};
            default: return 16'h0;
        endcase
    endfunction

    task automatic step(input logic [15:0] wa, input logic [15:0] wd, input logic [1:0] we);
        dwrite_addr = wa; dwrite_data = wd; dwrite_en = we;
        @(posedge clk);
        model_edge(wa, wd, we);
        #1;
        dwrite_en = 2'b00;
    endtask

    task automatic wr(input int idx, input logic [15:0] wd, input logic [1:0] we);
        step(BASE + 16'(idx * 2), wd, we);
    endtask

    task automatic idle();
        step(16'h0000, 16'h0000, 2'b00);
    endtask

    task automatic chk_addr(input string tag, input logic [15:0] a);
        dread_addr = a;
        #1;
        check_val(tag, dread_data, mread(a));
    endtask

    task automatic chk_reg(input string tag, input int idx);
        chk_addr(tag, BASE + 16'(idx * 2) + 16'($urandom_range(0, 1)));
    endtask

    task automatic chk_irq(input string tag);
        check_val(tag, {15'd0, interrupt}, {15'd0, m_pend & m_ie});
    endtask

    task automatic chk_const(input string tag, input int idx, input logic [15:0] exp);
        dread_addr = BASE + 16'(idx * 2);
        #1;
        check_val(tag, dread_data, exp);
    endtask

    int          r, ridx;
    logic [15:0] wa, wd;
    logic [1:0]  we;

    initial begin
        reset = 1'b0; dread_addr = 0; dwrite_addr = 0; dwrite_data = 0; dwrite_en = 0;
        model_reset();
        #25 reset = 1'b1;

        for (int i = 0; i < 8; i++) chk_const("rst_reg", i, 16'h0000);
        check_val("rst_irq", {15'd0, interrupt}, 16'h0000);

        // byte lanes
        wr(2, 16'hABCD, 2'b01);
        chk_const("lane_lo", 2, 16'h00CD);
        wr(2, 16'h1200, 2'b10);
        chk_const("lane_hi", 2, 16'h12CD);

        // one-shot: PRESCALE=0, COUNT=3, EN|IE at edge 0
        wr(1, 16'h0000, 2'b11);
        wr(3, 16'h0003, 2'b11);
        wr(0, 16'h0003, 2'b11);
        for (int e = 1; e <= 3; e++) idle();
        chk_const("os_pre", 4, 16'h0000);
        check_val("os_irq_pre", {15'd0, interrupt}, 16'h0000);
        idle();
        chk_const("os_pend", 4, 16'h0001);
        check_val("os_irq", {15'd0, interrupt}, 16'h0001);
        chk_const("os_ctrl", 0, 16'h0002);
        chk_const("os_cnt", 3, 16'h0000);
        wr(4, 16'h0001, 2'b01);
        check_val("os_w1c_irq", {15'd0, interrupt}, 16'h0000);

        // auto-reload: PRESCALE=2, RELOAD=1, COUNT=1, EN|IE|AUTO at edge 0
        wr(1, 16'h0002, 2'b11);
        wr(2, 16'h0001, 2'b11);
        wr(3, 16'h0001, 2'b11);
        wr(0, 16'h0007, 2'b11);
        for (int e = 1; e <= 5; e++) idle();
        chk_const("ar_pre6", 4, 16'h0000);
        idle();
        chk_const("ar_e6", 4, 16'h0001);
        wr(4, 16'h0001, 2'b01);
        for (int e = 8; e <= 11; e++) idle();
        chk_const("ar_pre12", 4, 16'h0000);
        idle();
        chk_const("ar_e12", 4, 16'h0001);
        chk_reg("ar_model", 3);
        wr(0, 16'h0000, 2'b11);
        wr(4, 16'h0001, 2'b01);

        // collision: COUNT write on the expiring tick edge
        wr(1, 16'h0001, 2'b11);
        wr(3, 16'h0000, 2'b11);
        wr(0, 16'h0001, 2'b11);
        idle();
        wr(3, 16'h0010, 2'b11);
        chk_const("col_cnt", 3, 16'h0010);
        chk_const("col_pend", 4, 16'h0000);
        wr(0, 16'h0000, 2'b11);

        // set wins over W1C on the expiry edge
        wr(1, 16'h0000, 2'b11);
        wr(3, 16'h0000, 2'b11);
        wr(0, 16'h0003, 2'b11);
        wr(4, 16'h0001, 2'b01);
        chk_const("sw_pend", 4, 16'h0001);
        check_val("sw_irq", {15'd0, interrupt}, 16'h0001);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            wa = 0; wd = 0; we = 0;
            if (r < 5) begin
                ridx = $urandom_range(0, 7);
                wa = BASE + 16'(ridx * 2) + 16'($urandom_range(0, 1));
                if (r == 0) wa = wa ^ 16'h0100;
                we = 2'($urandom_range(1, 3));
                wd = 16'($urandom);
                if (ridx >= 1 && ridx <= 3) wd = 16'($urandom_range(0, 5));
            end
            step(wa, wd, we);
            chk_irq("rnd_irq");
            chk_reg("rnd_cnt", 3);
            chk_reg("rnd_reg", $urandom_range(0, 7));
            if (r == 9) chk_addr("rnd_out", 16'($urandom) & 16'hFEFF);
        end

        // asynchronous reset mid-cycle with a pending interrupt
        wr(4, 16'h0001, 2'b01);
        wr(1, 16'h0000, 2'b11);
        wr(3, 16'h0000, 2'b11);
        wr(0, 16'h0007, 2'b11);
        idle();
        check_val("pre_rst_irq", {15'd0, interrupt}, 16'h0001);
        #3 reset = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 8; i++) chk_const("arst_reg", i, 16'h0000);
        check_val("arst_irq", {15'd0, interrupt}, 16'h0000);
        dread_addr = BASE + 16'd16;
        #1;
        check_val("arst_out", dread_data, 16'h0000);
        #2 reset = 1'b1;
        idle();
        chk_reg("post_rst", 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
